// File: rtl/ped_signal_ctrl_pkg.sv
// Shared encodings, state type and default timings for the pedestrian signal controller.
package ped_signal_ctrl_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam logic [1:0] PED_DONT_WALK = 2'b00;
  localparam logic [1:0] PED_WALK      = 2'b01;
  localparam logic [1:0] PED_FLASH     = 2'b10;

  typedef enum logic [1:0] {
    ST_DW    = PED_DONT_WALK,
    ST_WALK  = PED_WALK,
    ST_FLASH = PED_FLASH
  } ped_state_t;

  localparam int DEFAULT_WALK_SEC  = 5;
  localparam int DEFAULT_FLASH_SEC = 3;

  // A light is well formed only when exactly one of its three lamps is lit.
  function automatic logic light_is_onehot(input logic [2:0] light);
    return (light == LIGHT_RED) || (light == LIGHT_YELLOW) || (light == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/ped_dir_fsm.sv
// One pedestrian direction: request latch, green-onset detect, DW/WALK/FLASH FSM and phase counter.
module ped_dir_fsm
  import ped_signal_ctrl_pkg::*;
#(
  parameter int WALK_SEC  = DEFAULT_WALK_SEC,
  parameter int FLASH_SEC = DEFAULT_FLASH_SEC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] light,
  input  logic       btn,
  input  logic       force_dw,
  output logic [1:0] ped,
  output logic       req,
  output logic [3:0] count
);

  ped_state_t state_r, state_s;
  logic [3:0] count_r, count_s;
  logic       req_r, req_s;
  logic [2:0] prev_light_r;
  logic       green_s, onset_s;

  assign green_s = (light == LIGHT_GREEN);
  assign onset_s = green_s && (prev_light_r != LIGHT_GREEN);

  // State, counter, request and previous-light registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_DW;
      count_r      <= 4'd0;
      req_r        <= 1'b0;
      prev_light_r <= LIGHT_RED;
    end else begin
      state_r      <= state_s;
      count_r      <= count_s;
      req_r        <= req_s;
      prev_light_r <= light;
    end
  end

  // Next-state, counter and request logic; a fault freezes the request and parks the FSM in DW.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    req_s   = req_r;
    if (force_dw) begin
      state_s = ST_DW;
      count_s = 4'd0;
    end else begin
      case (state_r)
        ST_DW: begin
          count_s = 4'd0;
          if (onset_s && (req_r || btn)) begin
            state_s = ST_WALK;
            count_s = 4'(WALK_SEC);
            req_s   = 1'b0;
          end else begin
            req_s = req_r | btn;
          end
        end
        ST_WALK: begin
          if (!green_s) begin
            state_s = ST_DW;
            count_s = 4'd0;
          end else if (count_r == 4'd0) begin
            state_s = ST_FLASH;
            count_s = 4'(FLASH_SEC);
          end else if (tick) begin
            count_s = count_r - 4'd1;
          end else begin
            count_s = count_r;
          end
        end
        ST_FLASH: begin
          req_s = req_r | btn;
          if (!green_s || (count_r == 4'd0)) begin
            state_s = ST_DW;
            count_s = 4'd0;
          end else if (tick) begin
            count_s = count_r - 4'd1;
          end else begin
            count_s = count_r;
          end
        end
        default: begin
          state_s = ST_DW;
          count_s = 4'd0;
        end
      endcase
    end
  end

  assign ped   = state_r;
  assign req   = req_r;
  assign count = count_r;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian signal controller: two direction FSMs plus the sticky illegal-light fault that parks both in DW.
module ped_signal_ctrl
  import ped_signal_ctrl_pkg::*;
#(
  parameter int WALK_SEC  = DEFAULT_WALK_SEC,
  parameter int FLASH_SEC = DEFAULT_FLASH_SEC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] NS_light,
  input  logic [2:0] EW_light,
  input  logic       ped_btn_ns,
  input  logic       ped_btn_ew,
  output logic [1:0] ns_ped,
  output logic [1:0] ew_ped,
  output logic       ns_req,
  output logic       ew_req,
  output logic [3:0] ns_count,
  output logic [3:0] ew_count,
  output logic       fault
);

  logic illegal_s, fault_r, force_dw_s;

  // The current illegal sample also forces DW so the outputs go dark together with fault.
  assign illegal_s = !light_is_onehot(NS_light) || !light_is_onehot(EW_light) ||
                     ((NS_light != LIGHT_RED) && (EW_light != LIGHT_RED));
  assign force_dw_s = fault_r | illegal_s;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_r | illegal_s;
    end
  end

  assign fault = fault_r;

  ped_dir_fsm #(.WALK_SEC(WALK_SEC), .FLASH_SEC(FLASH_SEC)) u_ns (
    .clk(clk), .rst(rst), .tick(tick), .light(NS_light), .btn(ped_btn_ns),
    .force_dw(force_dw_s), .ped(ns_ped), .req(ns_req), .count(ns_count)
  );

  ped_dir_fsm #(.WALK_SEC(WALK_SEC), .FLASH_SEC(FLASH_SEC)) u_ew (
    .clk(clk), .rst(rst), .tick(tick), .light(EW_light), .btn(ped_btn_ew),
    .force_dw(force_dw_s), .ped(ew_ped), .req(ew_req), .count(ew_count)
  );

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl with a per-cycle behavioural model and literal spot checks.
module tb_ped_signal_ctrl;

  localparam int W = 5;
  localparam int F = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_ns = 1'b0;
  logic       btn_ew = 1'b0;
  logic [2:0] ns_l = 3'b100;
  logic [2:0] ew_l = 3'b100;
  logic [1:0] ns_ped, ew_ped;
  logic       ns_req, ew_req, fault;
  logic [3:0] ns_count, ew_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: phase 0=DONT_WALK 1=WALK 2=FLASH (numerically the output code), remaining ticks, request, green last cycle.
  int m_ph[2];
  int m_cnt[2];
  bit m_req[2];
  bit m_pg[2];
  bit m_fault;

  ped_signal_ctrl #(.WALK_SEC(W), .FLASH_SEC(F)) dut (
    .clk(clk), .rst(rst), .tick(tick), .NS_light(ns_l), .EW_light(ew_l),
    .ped_btn_ns(btn_ns), .ped_btn_ew(btn_ew), .ns_ped(ns_ped), .ew_ped(ew_ped),
    .ns_req(ns_req), .ew_req(ew_req), .ns_count(ns_count), .ew_count(ew_count),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin : model
    bit illegal, frc, g, on, b;
    logic [2:0] l;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_ph[d] = 0; m_cnt[d] = 0; m_req[d] = 1'b0; m_pg[d] = 1'b0;
      end
      m_fault = 1'b0;
    end else begin
      illegal = ($countones(ns_l) != 1) || ($countones(ew_l) != 1) ||
                ((ns_l != 3'b100) && (ew_l != 3'b100));
      frc = m_fault || illegal;
      m_fault = m_fault || illegal;
      for (int d = 0; d < 2; d++) begin
        l = (d == 1) ? ew_l : ns_l;
        b = (d == 1) ? btn_ew : btn_ns;
        g = (l == 3'b001);
        on = g && !m_pg[d];
        m_pg[d] = g;
        if (frc) begin
          m_ph[d] = 0; m_cnt[d] = 0;
        end else if (m_ph[d] == 0) begin
          if (on && (m_req[d] || b)) begin
            m_ph[d] = 1; m_cnt[d] = W; m_req[d] = 1'b0;
          end else begin
            m_req[d] = m_req[d] | b;
          end
        end else begin
          if (m_ph[d] == 2) m_req[d] = m_req[d] | b;
          if (!g) begin
            m_ph[d] = 0; m_cnt[d] = 0;
          end else if (m_cnt[d] == 0) begin
            m_ph[d] = (m_ph[d] == 1) ? 2 : 0;
            m_cnt[d] = (m_ph[d] == 2) ? F : 0;
          end else if (tick) begin
            m_cnt[d] = m_cnt[d] - 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ns_ped", ns_ped, m_ph[0]);
      chk("ew_ped", ew_ped, m_ph[1]);
      chk("ns_count", ns_count, m_cnt[0]);
      chk("ew_count", ew_count, m_cnt[1]);
      chk("ns_req", ns_req, m_req[0]);
      chk("ew_req", ew_req, m_req[1]);
      chk("fault", fault, m_fault);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(9);
  endtask

  initial begin
    #1 rst = 1'b0;
    step(2);
    chk("rst_ns_ped", ns_ped, 0);
    chk("rst_ew_ped", ew_ped, 0);
    chk("rst_ns_count", ns_count, 0);
    chk("rst_req", ns_req | ew_req, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b1;
    chk_en = 1'b1;
    step(2);

    // EW green onset without any request stays dark
    ew_l = 3'b001; step(2);
    chk("ew_onset_noreq", ew_ped, 0);
    ew_l = 3'b100; step(1);

    // Request latched on red, consumed at green onset
    btn_ns = 1'b1; step(1); btn_ns = 1'b0;
    chk("ns_req_latched", ns_req, 1);
    ns_l = 3'b001; step(1);
    chk("walk_ped", ns_ped, 1);
    chk("walk_count", ns_count, 5);
    chk("walk_req_clr", ns_req, 0);
    btn_ns = 1'b1; step(1); btn_ns = 1'b0;
    chk("walk_btn_ignored", ns_req, 0);

    // Full WALK then FLASH timing
    repeat (5) tick_pulse();
    chk("flash_ped", ns_ped, 2);
    chk("flash_count", ns_count, 3);
    repeat (2) tick_pulse();
    chk("flash_count1", ns_count, 1);
    tick_pulse();
    chk("flash_done_ped", ns_ped, 0);
    chk("flash_done_count", ns_count, 0);

    // Green lost mid-WALK aborts without FLASH
    ns_l = 3'b010; step(1);
    ns_l = 3'b100; step(1);
    btn_ns = 1'b1; step(1); btn_ns = 1'b0;
    ns_l = 3'b001; step(1);
    chk("walk2_ped", ns_ped, 1);
    repeat (2) tick_pulse();
    chk("walk2_count3", ns_count, 3);
    ns_l = 3'b010; step(1);
    chk("abort_ped", ns_ped, 0);
    chk("abort_count", ns_count, 0);
    step(3);
    chk("abort_no_flash", ns_ped, 0);

    // Button in the same cycle as the EW green onset
    ns_l = 3'b100;
    btn_ew = 1'b1; ew_l = 3'b001; step(1); btn_ew = 1'b0;
    chk("ew_same_cycle_walk", ew_ped, 1);
    chk("ew_walk_count", ew_count, 5);

    // Both green -> sticky fault, both dark, request frozen
    ns_l = 3'b001; step(1);
    chk("fault_both_green", fault, 1);
    chk("fault_ns_dark", ns_ped, 0);
    chk("fault_ew_dark", ew_ped, 0);
    ns_l = 3'b100; ew_l = 3'b100;
    btn_ns = 1'b1; step(1); btn_ns = 1'b0;
    step(3);
    chk("fault_sticky", fault, 1);
    chk("fault_req_held", ns_req, 0);
    rst = 1'b0; #1;
    chk("fault_cleared", fault, 0);
    step(2);

    // Non-one-hot light also faults
    ns_l = 3'b011; rst = 1'b1; step(1);
    chk("fault_not_onehot", fault, 1);
    ns_l = 3'b100; rst = 1'b0; step(1);
    rst = 1'b1; step(1);
    chk("fault_reset_clean", fault, 0);

    // Asynchronous reset in the middle of FLASH
    btn_ns = 1'b1; step(1); btn_ns = 1'b0;
    ns_l = 3'b001; step(1);
    chk("walk3_ped", ns_ped, 1);
    repeat (5) tick_pulse();
    chk("flash3_ped", ns_ped, 2);
    tick = 1'b1; step(1); tick = 1'b0;
    chk("flash3_count2", ns_count, 2);
    #1 rst = 1'b0; #1;
    chk("async_ns_ped", ns_ped, 0);
    chk("async_ns_count", ns_count, 0);
    chk("async_ns_req", ns_req, 0);
    chk("async_fault", fault, 0);
    step(2);
    rst = 1'b1; step(3);
    chk("post_rst_green_noreq", ns_ped, 0);

    // Request raised mid-green waits for the next onset
    btn_ns = 1'b1; step(1); btn_ns = 1'b0; step(1);
    chk("midgreen_req", ns_req, 1);
    chk("midgreen_stays_dw", ns_ped, 0);
    ns_l = 3'b010; step(1);
    ns_l = 3'b100; step(1);
    ns_l = 3'b001; step(1);
    chk("next_onset_walk", ns_ped, 1);
    step(2);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ped_signal_ctrl.md
PED_SIGNAL_CTRL -- requirements
Module: ped_signal_ctrl

Interface
REQ-001 SHALL have parameter WALK_SEC, default 5: WALK duration in ticks.
REQ-002 SHALL have parameter FLASH_SEC, default 3: FLASH duration in ticks.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port tick, input, 1: one-cycle-wide 1 Hz enable pulse.
REQ-006 SHALL have port NS_light, input, 3: one-hot North-South vehicle light (red=100, yellow=010, green=001).
REQ-007 SHALL have port EW_light, input, 3: one-hot East-West vehicle light, same encoding.
REQ-008 SHALL have ports ped_btn_ns and ped_btn_ew, input, 1 each: pre-synchronised, level-sampled pedestrian buttons.
REQ-009 SHALL have ports ns_ped and ew_ped, output, 2 each: pedestrian signal (DONT_WALK=00, WALK=01, FLASH=10; 11 never driven).
REQ-010 SHALL have ports ns_req and ew_req, output, 1 each: latched request pending.
REQ-011 SHALL have ports ns_count and ew_count, output, 4 each: remaining ticks in the current WALK/FLASH phase, 0 in DONT_WALK.
REQ-012 SHALL have port fault, output, 1: sticky illegal-light indication.

Function
REQ-013 Each direction SHALL run an independent FSM with states DW, WALK and FLASH; NS pedestrians are tied to NS_light, EW pedestrians to EW_light.
REQ-014 Green onset SHALL be a cycle where the light equals green and its registered previous-cycle sample did not.
REQ-015 A button sampled high SHALL set the request in the next cycle when the FSM is DW or FLASH; the button SHALL be ignored in WALK.
REQ-016 In DW, a green onset with the request set, or with the button high in that same cycle, SHALL enter WALK next cycle, load count=WALK_SEC and clear the request.
REQ-017 A green onset without a request SHALL leave the FSM in DW; a request raised mid-green SHALL wait for the next green onset.
REQ-018 The count SHALL decrement by 1 on each tick while it is nonzero and SHALL never wrap below 0.
REQ-019 WALK with count==0 SHALL move to FLASH next cycle and load FLASH_SEC; FLASH with count==0 SHALL move to DW next cycle with count 0.
REQ-020 If the light stops being green while the FSM is in WALK or FLASH, the FSM SHALL go to DW next cycle with count 0; the pending request SHALL be kept.
REQ-021 fault SHALL set next cycle, and stay set until reset, when either light is not one-hot, or when neither light is red.
REQ-022 While fault=1, both FSMs SHALL be forced to DW, requests SHALL be held, and no WALK SHALL be entered.
REQ-023 All outputs SHALL be registered, and *_ped SHALL equal the FSM state encoding.

Reset
REQ-024 rst low SHALL asynchronously force both FSMs to DW (ns_ped=ew_ped=00), counts to 0, ns_req=ew_req=0, fault=0, and previous-light samples to red (100).
REQ-025 Reset asserted mid-WALK SHALL drop the requests; after release, the first green SHALL count as an onset only if a request exists.

Structure
REQ-026 A shared package SHALL hold the light encodings (red, yellow, green), the pedestrian encodings (DONT_WALK, WALK, FLASH), the FSM state typedef and the default WALK_SEC/FLASH_SEC values.
REQ-027 The per-direction logic (request latch, edge detect, FSM, counter) SHALL be one sub-module, ped_dir_fsm, instantiated twice.
REQ-028 The fault detector and the force-to-DW gating SHALL live in the ped_signal_ctrl top level.

Verification
REQ-029 Scenario: ped_btn_ns pulses while NS_light=100, then NS_light goes to 001 -> ns_req=1, then ns_ped=01 with ns_count=5 one cycle after onset, ns_req=0.
REQ-030 Scenario: steady NS green, tick every 10 cycles -> WALK lasts 5 ticks, then ns_ped=10 with ns_count=3, then 00 after 3 more ticks.
REQ-031 Scenario: NS_light goes to 010 during WALK at ns_count=3 -> ns_ped=00 and ns_count=0 next cycle, with no FLASH.
REQ-032 Scenario: green onset with no button press -> ns_ped stays 00; ped_btn_ew high in the same cycle as the EW green onset -> ew_ped=01 next cycle.
REQ-033 Scenario: NS_light=001 and EW_light=001, or NS_light=011 -> fault=1 next cycle, both outputs 00; fault stays set until rst low.
REQ-034 Scenario: rst low mid-FLASH -> all outputs at reset values immediately, with no clk edge required.
